// File: rtl/wb_pkg.sv
// Shared Wishbone encodings, FSM state type and the burst address step used by wb_bram_burst.
// Consumers compile burst support only when WB_BRAM_BURST_EN is defined.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_BURST = 2'd2
  } wb_state_e;

  // Wrapping bursts only advance the low word-index bits; linear rolls over naturally.
  function automatic logic [31:0] wb_next_idx(input logic [31:0] idx, input logic [1:0] bte);
    logic [31:0] inc;
    inc = idx + 32'd1;
    case (bte)
      BTE_WRAP4:  return {idx[31:2], inc[1:0]};
      BTE_WRAP8:  return {idx[31:3], inc[2:0]};
      BTE_WRAP16: return {idx[31:4], inc[3:0]};
      default:    return inc;
    endcase
  endfunction

endpackage

// File: rtl/wb_bram_mem.sv
// Inferred single-port byte-enable RAM with registered read (read-before-write).
// The read register clears on reset, the array never does.
module wb_bram_mem #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter     INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW/8-1:0] we_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++) begin
      if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave with classic cycles and, under WB_BRAM_BURST_EN,
// registered-feedback incrementing bursts (linear / wrap-4 / wrap-8 / wrap-16).
module wb_bram_burst
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  input  logic                    we_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic [2:0]              cti_i,
  input  logic [1:0]              bte_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output wb_state_e               dbg_state_o
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(SW);
  localparam int WA  = ADDR_WIDTH - OFF;

  // Handshake: a beat transfers on a rising edge where cyc_i & stb_i & ack_o are all high;
  // the master holds adr/dat/sel/we/cti/bte stable until that edge.
  wb_state_e      state_q;
  logic           ack_q;
  logic [WA-1:0]  adr_word;
  logic [WA-1:0]  mem_addr;
  logic [SW-1:0]  mem_we;
  logic           request;
  logic           accept;

  assign adr_word    = adr_i[ADDR_WIDTH-1:OFF];
  assign request     = cyc_i & stb_i;
  assign accept      = request & ack_o;
  assign dbg_state_o = state_q;

  generate
    if (OFF > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^adr_i[OFF-1:0];
    end
  endgenerate

`ifdef WB_BRAM_BURST_EN
  logic [WA-1:0] badr_q;
  logic [WA-1:0] adr_nxt;
  logic [WA-1:0] badr_nxt;
  logic          burst_ok;

  assign adr_nxt  = WA'(wb_next_idx(32'(adr_word), bte_i));
  assign badr_nxt = WA'(wb_next_idx(32'(badr_q), bte_i));
  assign burst_ok = (adr_word == badr_q);

  // Inside a burst the prefetched ack is withheld while the master waits or jumps address.
  assign ack_o = ack_q & ~((state_q == ST_BURST) & (~stb_i | ~burst_ok));

  always_comb begin
    mem_addr = adr_word;
    mem_we   = '0;
    if (accept && we_i) begin
      mem_we = sel_i;
    end else if (state_q == ST_ACK && accept && cti_i == CTI_INCR) begin
      mem_addr = adr_nxt;
    end else if (state_q == ST_BURST && !(request && !burst_ok)) begin
      mem_addr = accept ? badr_nxt : badr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      badr_q  <= '0;
    end else if (!cyc_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stb_i) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end
        end
        ST_ACK: begin
          if (accept && cti_i == CTI_INCR) begin
            state_q <= ST_BURST;
            ack_q   <= 1'b1;
            badr_q  <= adr_nxt;
          end else begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
          end
        end
        ST_BURST: begin
          if (!stb_i) begin
            ack_q <= 1'b0;
          end else if (!burst_ok) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end else if (!ack_q) begin
            ack_q <= 1'b1;
          end else if (cti_i == CTI_INCR) begin
            badr_q <= badr_nxt;
          end else begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_burst;
  assign unused_burst = ^{cti_i, bte_i};

  assign ack_o = ack_q;

  always_comb begin
    mem_addr = adr_word;
    mem_we   = '0;
    if (accept && we_i) mem_we = sel_i;
  end

  // Classic only: every request costs one wait cycle, so acks come every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else if (!cyc_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stb_i) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end
`endif

  wb_bram_mem #(
    .AW        (WA),
    .DW        (DATA_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr_i  (mem_addr),
    .we_i    (mem_we),
    .wdata_i (dat_i),
    .rdata_o (dat_o)
  );

endmodule
